mdu_wb_fifo: RTL and testbench
==============================

Name: mdu_wb_fifo

Overview:
- Receives completed results from the MDU issue queue over the `entry_valid`/`fifo_ready` handshake and buffers them.
- Presents buffered results in order to the CDB arbiter, which pulls them using a valid/ready grant.
- Decouples multi-cycle MDU completion from CDB port availability.
- Flushed with the rest of the backend on redirect.

Parameters:
- DEPTH, 4, number of buffered results; must be a power of 2, at least 2.
- PTR_LEN, $clog2(DEPTH), head/tail pointer width (derived).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  backend flush; clears all entries.
- entry_valid_i  in  1  result from the MDU issue queue is valid this cycle.
- result_i  in  cdb_info_t  result payload (w_data, rob_id, w_reg, r_valid, lsu_info, ctrl).
- fifo_ready_o  out  1  FIFO can accept a result this cycle.
- cdb_valid_o  out  1  head entry is presented to the CDB arbiter.
- cdb_o  out  cdb_info_t  head entry payload.
- cdb_ready_i  in  1  CDB arbiter grants the head entry this cycle.
- count_o  out  PTR_LEN+1  number of occupied entries.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values, applied when `!rst_n` or `flush` at a clk edge:
  - head=0, tail=0, count=0.
  - fifo_ready_o=1, cdb_valid_o=0, cdb_o='0, count_o=0.
  - Payload storage is not reset.
- Push:
  - Push occurs when `entry_valid_i & fifo_ready_o`.
  - result_i is written to mem[tail], then tail <= tail+1.
- Pop:
  - Pop occurs when `cdb_valid_o & cdb_ready_i`.
  - head <= head+1.
- count update: count <= count + push - pop.
- Output derivation:
  - fifo_ready_o = (count != DEPTH). It depends only on registered state, with no combinational path from cdb_ready_i or entry_valid_i.
  - cdb_valid_o = (count != 0).
  - cdb_o = mem[head] when count != 0, else '0.
  - count_o = count.
- Latency: a pushed result is visible on cdb_o no earlier than the cycle after the push (1-cycle minimum).
- Full: fifo_ready_o=0, so an incoming valid is not accepted even if a pop happens in the same cycle. The producer holds result_i and entry_valid_i until accepted.
- Empty: cdb_valid_o=0. A simultaneous push makes the entry visible next cycle.
- Simultaneous push and pop (0 < count < DEPTH): count is unchanged, both pointers advance, order is preserved.
- Wrap-around: pointers are PTR_LEN bits and wrap modulo DEPTH naturally. Ordering across the wrap is strict FIFO.
- Payload is stored unmodified:
  - Entries with r_valid=0 or ctrl.exc_info.fetch_exception=1 are still queued, so the ROB sees completion.
  - No filtering, no reordering.
- Flush has priority over push and pop in the same cycle. Data presented during a flush cycle is dropped.
- Reset asserted mid-stream has the same effect as flush.
- cdb_ready_i while cdb_valid_o=0 is ignored.

Optional Feature:
- Macro: MDU_WB_FIFO_BYPASS_EN.
- With the macro defined, when count==0 and entry_valid_i=1:
  - cdb_valid_o=1 and cdb_o=result_i combinationally in the same cycle.
  - If cdb_ready_i=1 in that cycle, the result is consumed without being written (count stays 0).
  - Otherwise it is pushed normally.
  - fifo_ready_o is unchanged (still count != DEPTH).
- Without the macro: strict 1-cycle minimum latency as above, with no combinational path from entry_valid_i or result_i to the outputs.

Test Plan:
- Fill and drain (DEPTH=4): after reset, push rob_id 1,2,3,4 on consecutive cycles with cdb_ready_i=0 → count_o=4, fifo_ready_o=0. Then hold cdb_ready_i=1 → cdb_o.rob_id 1,2,3,4 in order, then cdb_valid_o=0, count_o=0.
- Full plus pop: count=4, entry_valid_i=1 with rob_id 5, cdb_ready_i=1 for one cycle → rob_id 1 popped, 5 not accepted (count_o=3). Next cycle 5 is accepted → count_o=4.
- Steady streaming with wrap: continuous push and pop every cycle for 10 results (rob_id 0..9) → count_o stays 1 after the first cycle, outputs 0..9 in order, tail wraps twice.
- Flush: count=3, assert flush together with entry_valid_i=1 → next cycle count_o=0, cdb_valid_o=0, fifo_ready_o=1, and the pushed entry is absent.
- Exception passthrough: push result_i with r_valid=0 and fetch_exception=1, exc_code=0x8 → cdb_o reproduces both fields bit-exact.
- Bypass on vs. off: empty FIFO, entry_valid_i=1 with rob_id 7, cdb_ready_i=1:
  - With MDU_WB_FIFO_BYPASS_EN: cdb_valid_o=1 the same cycle, count_o remains 0.
  - Without it: cdb_valid_o=0 that cycle, then valid with rob_id 7 the next cycle.

Source files
------------

// File: rtl/mdu_wb_fifo.sv
// MDU writeback FIFO: buffers completed MDU results in order until the CDB arbiter grants them.
// Optional same-cycle bypass when empty is enabled by defining MDU_WB_FIFO_BYPASS_EN.
package mdu_wb_pkg;
    typedef struct packed {
        logic       fetch_exception;
        logic [3:0] exc_code;
    } exc_info_t;

    typedef struct packed {
        exc_info_t exc_info;
        logic      is_mdu;
    } ctrl_t;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic [1:0] ls_size;
    } lsu_info_t;

    typedef struct packed {
        logic [31:0] w_data;
        logic [5:0]  rob_id;
        logic [4:0]  w_reg;
        logic        r_valid;
        lsu_info_t   lsu_info;
        ctrl_t       ctrl;
    } cdb_info_t;
endpackage

module mdu_wb_fifo
    import mdu_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     entry_valid_i,
    input  cdb_info_t                result_i,
    output logic                     fifo_ready_o,
    output logic                     cdb_valid_o,
    output cdb_info_t                cdb_o,
    input  logic                     cdb_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int                 PTR_LEN = $clog2(DEPTH);
    localparam logic [PTR_LEN:0]   L_FULL  = (PTR_LEN+1)'(DEPTH);
    localparam logic [PTR_LEN-1:0] L_PTR1  = PTR_LEN'(1);
    localparam logic [PTR_LEN:0]   L_CNT1  = (PTR_LEN+1)'(1);

    cdb_info_t          r_mem [DEPTH];
    logic [PTR_LEN-1:0] r_head;
    logic [PTR_LEN-1:0] r_tail;
    logic [PTR_LEN:0]   r_count;

    logic w_nempty;
    logic w_push;
    logic w_pop;

    assign w_nempty     = (r_count != '0);
    assign fifo_ready_o = (r_count != L_FULL);
    assign count_o      = r_count;
    assign w_pop        = w_nempty & cdb_ready_i;

`ifdef MDU_WB_FIFO_BYPASS_EN
    logic w_byp;
    logic w_byp_take;

    // An empty FIFO forwards the incoming result directly; if granted, it is never stored.
    assign w_byp       = ~w_nempty & entry_valid_i;
    assign w_byp_take  = w_byp & cdb_ready_i;
    assign w_push      = entry_valid_i & fifo_ready_o & ~w_byp_take;
    assign cdb_valid_o = w_nempty | w_byp;
    assign cdb_o       = w_nempty ? r_mem[r_head] : (w_byp ? result_i : '0);
`else
    assign w_push      = entry_valid_i & fifo_ready_o;
    assign cdb_valid_o = w_nempty;
    assign cdb_o       = w_nempty ? r_mem[r_head] : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + L_PTR1;
            if (w_pop)  r_head <= r_head + L_PTR1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + L_CNT1;
                2'b01:   r_count <= r_count - L_CNT1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload is never reset; a write during flush is harmless since tail does not advance.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= result_i;
    end
endmodule

// File: tb/tb_mdu_wb_fifo.sv
// Scoreboard bench for mdu_wb_fifo: directed scenarios followed by randomized traffic.
module tb_mdu_wb_fifo;
    import mdu_wb_pkg::*;

    localparam int DEPTH = 4;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      flush = 1'b0;
    logic      entry_valid_i = 1'b0;
    cdb_info_t result_i = '0;
    logic      fifo_ready_o;
    logic      cdb_valid_o;
    cdb_info_t cdb_o;
    logic      cdb_ready_i = 1'b0;
    logic [2:0] count_o;

    int        checks = 0;
    int        failures = 0;
    cdb_info_t exp_q[$];
    bit        mon_en = 1'b0;
    bit        g_taken = 1'b0;

    mdu_wb_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .entry_valid_i(entry_valid_i),
        .result_i     (result_i),
        .fifo_ready_o (fifo_ready_o),
        .cdb_valid_o  (cdb_valid_o),
        .cdb_o        (cdb_o),
        .cdb_ready_i  (cdb_ready_i),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic cdb_info_t mk(input logic [5:0] rob);
        cdb_info_t r;
        r = '0;
        r.w_data                    = $urandom;
        r.rob_id                    = rob;
        r.w_reg                     = 5'($urandom);
        r.r_valid                   = 1'($urandom);
        r.lsu_info.is_load          = 1'($urandom);
        r.lsu_info.is_store         = 1'($urandom);
        r.lsu_info.ls_size          = 2'($urandom);
        r.ctrl.is_mdu               = 1'b1;
        r.ctrl.exc_info.fetch_exception = 1'($urandom);
        r.ctrl.exc_info.exc_code    = 4'($urandom);
        return r;
    endfunction

    // Monitor: the reference FIFO is the queue exp_q; its size is the expected occupancy.
    always @(negedge clk) begin
        int sz;
        bit byp;
        if (mon_en) begin
            sz  = exp_q.size();
            byp = 1'b0;
`ifdef MDU_WB_FIFO_BYPASS_EN
            byp = (sz == 0) && entry_valid_i;
`endif
            chk("count_o", 128'(count_o), 128'(sz));
            chk("fifo_ready_o", 128'(fifo_ready_o), 128'(sz != DEPTH));
            chk("cdb_valid_o", 128'(cdb_valid_o), 128'((sz != 0) || byp));
            if (sz != 0)
                chk("cdb_o_head", 128'(cdb_o), 128'(exp_q[0]));
            else if (byp)
                chk("cdb_o_bypass", 128'(cdb_o), 128'(result_i));
            else
                chk("cdb_o_empty", 128'(cdb_o), 128'(0));
            if (sz != 0 && cdb_ready_i && rst_n && !flush)
                void'(exp_q.pop_front());
        end
    end

    // Drive one cycle; the expected push is recorded once the edge has been taken.
    task automatic cyc(input logic ev, input cdb_info_t res, input logic rdy,
                       input logic fl, input logic rn);
        bit acc;
        bit byp_take;
        entry_valid_i = ev;
        result_i      = res;
        cdb_ready_i   = rdy;
        flush         = fl;
        rst_n         = rn;
        acc      = ev && rn && !fl && (exp_q.size() < DEPTH);
        byp_take = 1'b0;
`ifdef MDU_WB_FIFO_BYPASS_EN
        if (acc && exp_q.size() == 0 && rdy) begin
            acc      = 1'b0;
            byp_take = 1'b1;
        end
`endif
        @(posedge clk);
        if (!rn || fl) exp_q.delete();
        else if (acc) exp_q.push_back(res);
        g_taken = acc || byp_take;
        #1;
    endtask

    initial begin
        cdb_info_t r5;
        cdb_info_t rx;
        cdb_info_t cur;
        logic      cv;
        int        rob;

        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("reset_count", 128'(count_o), 128'(0));
        chk("reset_ready", 128'(fifo_ready_o), 128'(1));

        // Fill, then full-plus-pop, then drain
        for (int i = 1; i <= 4; i++) cyc(1'b1, mk(6'(i)), 1'b0, 1'b0, 1'b1);
        chk("fill_count", 128'(count_o), 128'(4));
        chk("fill_ready", 128'(fifo_ready_o), 128'(0));
        r5 = mk(6'd5);
        cyc(1'b1, r5, 1'b1, 1'b0, 1'b1);
        chk("fullpop_count", 128'(count_o), 128'(3));
        cyc(1'b1, r5, 1'b0, 1'b0, 1'b1);
        chk("refill_count", 128'(count_o), 128'(4));
        repeat (5) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("drain_valid", 128'(cdb_valid_o), 128'(0));

        // Streaming across pointer wrap
        for (int i = 0; i < 10; i++) cyc(1'b1, mk(6'(i)), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("stream_count", 128'(count_o), 128'(0));

        // Flush with a concurrent push
        for (int i = 0; i < 3; i++) cyc(1'b1, mk(6'(10 + i)), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, mk(6'd20), 1'b0, 1'b1, 1'b1);
        chk("flush_count", 128'(count_o), 128'(0));
        chk("flush_valid", 128'(cdb_valid_o), 128'(0));
        chk("flush_ready", 128'(fifo_ready_o), 128'(1));
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Exception payload passthrough
        rx = mk(6'd33);
        rx.r_valid = 1'b0;
        rx.ctrl.exc_info.fetch_exception = 1'b1;
        rx.ctrl.exc_info.exc_code = 4'h8;
        cyc(1'b1, rx, 1'b0, 1'b0, 1'b1);
        chk("exc_r_valid", 128'(cdb_o.r_valid), 128'(0));
        chk("exc_fetch", 128'(cdb_o.ctrl.exc_info.fetch_exception), 128'(1));
        chk("exc_code", 128'(cdb_o.ctrl.exc_info.exc_code), 128'(8));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Empty FIFO, valid and grant together
        cyc(1'b1, mk(6'd7), 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic; the producer holds an offered result until it is taken
        cv  = 1'b0;
        cur = '0;
        rob = 40;
        for (int n = 0; n < 1500; n++) begin
            logic fl;
            logic rn;
            logic rdy;
            if (!cv && $urandom_range(0, 99) < 60) begin
                cv  = 1'b1;
                cur = mk(6'(rob));
                rob++;
            end
            fl  = ($urandom_range(0, 99) < 3);
            rn  = ($urandom_range(0, 99) >= 1);
            rdy = 1'($urandom_range(0, 1));
            cyc(cv, cur, rdy, fl, rn);
            if (g_taken || fl || !rn) cv = 1'b0;
        end
        repeat (6) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("final_count", 128'(count_o), 128'(0));

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
